// File: rtl/sram_arb_pkg.sv
// Shared definitions for the IF/MEM SRAM port arbiter: FSM state codes,
// access owner encoding and internal counter widths.
package sram_arb_pkg;

    // Width of the read-latency down-counter (RD_LAT up to 7).
    localparam int LAT_W    = 3;
    // Width of the consecutive-data-grant counter (MAX_DSTREAK up to 15).
    localparam int STREAK_W = 4;

    // Arbiter FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Which requester owns the access currently in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection between fetch and data requesters. Data normally wins,
// but after MAX_DSTREAK consecutive data grants with a fetch waiting the
// fetch is let through so the IF stage cannot starve.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 3
) (
    input  logic   cpu_clk_50M,
    input  logic   cpu_rst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant_en,
    output owner_t owner,
    output logic   grant_valid
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    logic [STREAK_W-1:0] streak_reg;
    logic                d_win;

    // Combinational winner for the current IDLE cycle.
    always_comb begin
        d_win       = d_req & (~i_req | (streak_reg < STREAK_MAX));
        owner       = d_win ? OWN_D : OWN_I;
        grant_valid = i_req | d_req;
    end

    // Count data grants that bypassed a waiting fetch; any other grant restarts the streak.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            streak_reg <= '0;
        end else if (grant_en && grant_valid) begin
            if (d_win && i_req) begin
                if (streak_reg != STREAK_MAX) begin
                    streak_reg <= streak_reg + STREAK_W'(1);
                end
            end else begin
                streak_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between the IF-stage fetch requester and
// the MEM-stage data requester. Each access runs IDLE -> ISSUE -> (WAIT) ->
// RESP; reads return data with a one-cycle valid pulse, and an exception
// flush cancels the response of an in-flight fetch.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int MAX_DSTREAK = 3
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        flush,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_stall,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        s_ce,
    output logic [3:0]  s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    logic [1:0]       state_reg;
    owner_t           owner_reg;
    logic [LAT_W-1:0] lat_reg;
    logic             kill_reg;
    logic [3:0]       s_we_reg;
    logic [31:0]      s_addr_reg;
    logic [31:0]      s_wdata_reg;
    logic [31:0]      i_rdata_reg;
    logic [31:0]      d_rdata_reg;

    owner_t           grant_owner;
    logic             grant_valid;
    logic             in_idle;

    assign in_idle = (state_reg == ST_IDLE);

    sram_arb_grant #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_grant (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .i_req       (i_req),
        .d_req       (d_req),
        .grant_en    (in_idle),
        .owner       (grant_owner),
        .grant_valid (grant_valid)
    );

    // Access sequencer: a nonzero captured write mask means a write, which skips WAIT.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_I;
            lat_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_owner;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (s_we_reg != 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        state_reg <= ST_WAIT;
                        lat_reg   <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_reg == '0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        lat_reg <= lat_reg - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM command registers, loaded on grant so they are stable for the whole ISSUE cycle.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            s_we_reg    <= '0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
        end else if (in_idle && grant_valid) begin
            if (grant_owner == OWN_D) begin
                s_addr_reg  <= d_addr;
                s_we_reg    <= d_we;
                s_wdata_reg <= d_wdata;
            end else begin
                s_addr_reg  <= i_addr;
                s_we_reg    <= 4'd0;
            end
        end else begin
            s_we_reg <= 4'd0;
        end
    end

    // Capture read data on the last WAIT cycle; a killed fetch leaves i_rdata untouched.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else if (state_reg == ST_WAIT && lat_reg == '0) begin
            if (owner_reg == OWN_D) begin
                d_rdata_reg <= s_rdata;
            end else if (!kill_reg && !flush) begin
                i_rdata_reg <= s_rdata;
            end
        end
    end

    // Remember a flush that hit an in-flight fetch until the arbiter is idle again.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            kill_reg <= 1'b0;
        end else if (in_idle) begin
            kill_reg <= 1'b0;
        end else if (owner_reg == OWN_I && flush) begin
            kill_reg <= 1'b1;
        end
    end

    // Output decode; a flush arriving in RESP itself also suppresses the fetch pulse.
    always_comb begin
        s_ce    = (state_reg == ST_ISSUE);
        s_we    = s_we_reg;
        s_addr  = s_addr_reg;
        s_wdata = s_wdata_reg;
        i_rdata = i_rdata_reg;
        d_rdata = d_rdata_reg;
        i_valid = (state_reg == ST_RESP) && (owner_reg == OWN_I) && !kill_reg && !flush;
        d_valid = (state_reg == ST_RESP) && (owner_reg == OWN_D);
        i_stall = i_req & ~i_valid;
        d_stall = d_req & ~d_valid;
    end

    // A granted request must stay up until completion; only a killed fetch may be withdrawn.
    hold_req_a: assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
        (state_reg != ST_IDLE) |->
            ((owner_reg == OWN_D) ? d_req : (i_req | kill_reg | flush)));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: an SRAM behavioural model, a transaction-level
// reference of the arbiter compared every cycle, and directed scenarios with
// literal expectations.
module tb_sram_port_arbiter;

    localparam int RD_LAT      = 2;
    localparam int MAX_DSTREAK = 3;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst     = 1'b1;
    logic        flush       = 1'b0;
    logic        i_req       = 1'b0;
    logic [31:0] i_addr      = '0;
    logic        d_req       = 1'b0;
    logic [3:0]  d_we        = '0;
    logic [31:0] d_addr      = '0;
    logic [31:0] d_wdata     = '0;
    logic [31:0] s_rdata     = '0;
    logic [31:0] i_rdata, d_rdata, s_addr, s_wdata;
    logic        i_valid, i_stall, d_valid, d_stall, s_ce;
    logic [3:0]  s_we;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    sram_port_arbiter #(
        .RD_LAT      (RD_LAT),
        .MAX_DSTREAK (MAX_DSTREAK)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .flush       (flush),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_valid     (i_valid),
        .i_stall     (i_stall),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .d_stall     (d_stall),
        .s_ce        (s_ce),
        .s_we        (s_we),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model: data valid RD_LAT cycles after the issue cycle
    logic [31:0] sram_mem [256];
    int          rd_cnt = 0;
    logic [31:0] rd_buf = '0;

    always @(posedge cpu_clk_50M) begin
        logic        ce_s;
        logic [3:0]  we_s;
        logic [31:0] a_s, wd_s;
        ce_s = s_ce; we_s = s_we; a_s = s_addr; wd_s = s_wdata;
        #1;
        s_rdata = 32'hBAD0BAD0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) s_rdata = rd_buf;
        end
        if (ce_s) begin
            if (we_s != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (we_s[b]) sram_mem[a_s[9:2]][8*b +: 8] = wd_s[8*b +: 8];
            end else begin
                rd_buf = sram_mem[a_s[9:2]];
                if (RD_LAT == 1) s_rdata = rd_buf;
                else rd_cnt = RD_LAT - 1;
            end
        end
    end

    // ---------------- Transaction-level reference model + per-cycle compare
    int          m_cyc = 0, m_issue = 0, m_done = 0, m_streak = 0;
    bit          m_busy = 0, m_own_d = 0, m_write = 0, m_killed = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [31:0] m_i_rdata = '0, m_d_rdata = '0;
    logic [3:0]  m_we = '0;
    logic        e_s_ce, e_i_valid, e_d_valid;
    logic [3:0]  e_s_we;

    // Observation of the DUT for the directed literal checks.
    logic [15:0] glog = '0;
    int          glen = 0, i_ce_cyc = 0, d_ce_cyc = 0;
    int          i_val_cyc = 0, d_val_cyc = 0, i_val_cnt = 0;

    always @(negedge cpu_clk_50M) begin
        bit d_win;
        bit is_d;
        m_cyc++;
        if (cpu_rst) begin
            m_busy = 0; m_streak = 0; m_killed = 0;
            m_i_rdata = '0; m_d_rdata = '0;
            chk("rst_s_ce", s_ce, 0);
            chk("rst_s_we", s_we, 0);
            chk("rst_s_addr", s_addr, 0);
            chk("rst_s_wdata", s_wdata, 0);
            chk("rst_i_valid", i_valid, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_i_stall", i_stall, i_req);
            chk("rst_d_stall", d_stall, d_req);
        end else begin
            if (m_busy && !m_own_d && m_cyc >= m_issue && flush) m_killed = 1;
            e_s_ce    = m_busy && (m_cyc == m_issue);
            e_s_we    = e_s_ce ? m_we : 4'd0;
            e_i_valid = m_busy && (m_cyc == m_done) && !m_own_d && !m_killed;
            e_d_valid = m_busy && (m_cyc == m_done) && m_own_d;
            if (e_s_ce && !m_write) m_rdata = sram_mem[m_addr[9:2]];
            if (e_i_valid) m_i_rdata = m_rdata;
            if (e_d_valid && !m_write) m_d_rdata = m_rdata;

            chk("s_ce", s_ce, e_s_ce);
            chk("s_we", s_we, e_s_we);
            if (e_s_ce) chk("s_addr", s_addr, m_addr);
            if (e_s_ce && m_write) chk("s_wdata", s_wdata, m_wdata);
            chk("i_valid", i_valid, e_i_valid);
            chk("d_valid", d_valid, e_d_valid);
            chk("i_rdata", i_rdata, m_i_rdata);
            chk("d_rdata", d_rdata, m_d_rdata);
            chk("i_stall", i_stall, i_req & ~e_i_valid);
            chk("d_stall", d_stall, d_req & ~e_d_valid);

            if (m_busy && m_cyc == m_done) begin
                m_busy = 0;
            end else if (!m_busy && (i_req || d_req)) begin
                d_win = d_req && (!i_req || m_streak < MAX_DSTREAK);
                if (d_win) begin
                    m_streak = i_req ? ((m_streak < MAX_DSTREAK) ? m_streak + 1 : m_streak) : 0;
                    m_own_d = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                end else begin
                    m_streak = 0;
                    m_own_d = 0; m_addr = i_addr; m_we = 4'd0; m_wdata = '0;
                end
                m_write  = (m_we != 4'd0);
                m_busy   = 1;
                m_killed = 0;
                m_issue  = m_cyc + 1;
                m_done   = m_issue + (m_write ? 1 : RD_LAT + 1);
            end
        end

        if (s_ce) begin
            is_d = !i_req || (s_addr != i_addr);
            glog = {glog[14:0], is_d};
            glen++;
            if (is_d) d_ce_cyc = m_cyc; else i_ce_cyc = m_cyc;
        end
        if (i_valid) begin i_val_cyc = m_cyc; i_val_cnt++; end
        if (d_valid) d_val_cyc = m_cyc;
    end

    // ---------------- Requester drivers
    task automatic fetch_stream(input logic [31:0] base, input int n);
        @(posedge cpu_clk_50M); #1;
        i_req = 1'b1; i_addr = base;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin @(negedge cpu_clk_50M); t++; end while (!i_valid && t < 60);
            checks++;
            if (!i_valid) begin
                errors++;
                $display("FAIL fetch_timeout: i_valid=0 after %0d cycles, expected 1 (addr %h)", t, i_addr);
            end else begin
                $display("fetch addr=%h rdata=%h", i_addr, i_rdata);
            end
            @(posedge cpu_clk_50M); #1;
            if (k == n - 1) i_req = 1'b0;
            else i_addr = base + 32'(4 * (k + 1));
        end
    endtask

    task automatic data_stream(input logic [31:0] base, input logic [3:0] we,
                               input logic [31:0] wbase, input int n);
        @(posedge cpu_clk_50M); #1;
        d_req = 1'b1; d_addr = base; d_we = we; d_wdata = wbase;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin @(negedge cpu_clk_50M); t++; end while (!d_valid && t < 60);
            checks++;
            if (!d_valid) begin
                errors++;
                $display("FAIL data_timeout: d_valid=0 after %0d cycles, expected 1 (addr %h)", t, d_addr);
            end else begin
                $display("data addr=%h we=%h wdata=%h rdata=%h", d_addr, d_we, d_wdata, d_rdata);
            end
            @(posedge cpu_clk_50M); #1;
            if (k == n - 1) begin
                d_req = 1'b0; d_we = 4'd0;
            end else begin
                d_addr  = base + 32'(4 * (k + 1));
                d_wdata = wbase + 32'(k + 1);
            end
        end
    endtask

    task automatic wait_ce(input string name);
        int t = 0;
        do begin @(negedge cpu_clk_50M); t++; end while (!s_ce && t < 20);
        checks++;
        if (!s_ce) begin
            errors++;
            $display("FAIL %s: s_ce=0 after %0d cycles, expected an issue", name, t);
        end
    endtask

    // ---------------- Directed scenarios
    initial begin
        int cnt0;
        for (int k = 0; k < 256; k++) sram_mem[k] = 32'hC0DE0000 + 32'(k);
        sram_mem[8'h01] = 32'h24020005;   // 0x00000004
        sram_mem[8'h80] = 32'h12345678;   // 0x80000200
        sram_mem[8'hE0] = 32'h40806000;   // 0xBFC00380

        repeat (3) @(posedge cpu_clk_50M);
        #1 cpu_rst = 1'b0;

        // Single fetch: issue-to-valid is RD_LAT+1 = 3 cycles.
        fetch_stream(32'h00000004, 1);
        chk("fetch_data", i_rdata, 32'h24020005);
        chk("fetch_latency", 32'(i_val_cyc - i_ce_cyc), 32'd3);

        // Simultaneous requests: the store goes first; a flush during it changes nothing.
        glog = '0; glen = 0;
        fork
            data_stream(32'h80000100, 4'hF, 32'hDEADBEEF, 1);
            fetch_stream(32'h00000014, 1);
            begin
                repeat (2) @(posedge cpu_clk_50M);
                #1 flush = 1'b1;
                @(posedge cpu_clk_50M);
                #1 flush = 1'b0;
            end
        join
        chk("store_first_glen", 32'(glen), 32'd2);
        chk("store_first_order", 32'(glog[1:0]), 32'h2);
        chk("store_mem", sram_mem[8'h40], 32'hDEADBEEF);

        // Streak limit: D,D,D,I,D,D,D,I.
        glog = '0; glen = 0;
        fork
            data_stream(32'h80000100, 4'hF, 32'h00000100, 6);
            fetch_stream(32'h00000008, 2);
        join
        chk("streak_glen", 32'(glen), 32'd8);
        chk("streak_order", 32'(glog[7:0]), 32'hEE);

        // Flush during WAIT of a fetch, then re-issue from the exception vector.
        @(posedge cpu_clk_50M); #1;
        i_req = 1'b1; i_addr = 32'h00000020;
        wait_ce("flush_issue");
        @(posedge cpu_clk_50M); #1 flush = 1'b1;
        @(posedge cpu_clk_50M); #1 flush = 1'b0; i_req = 1'b0;
        cnt0 = i_val_cnt;
        repeat (5) @(negedge cpu_clk_50M);
        $display("fetch addr=00000020 killed by flush");
        chk("flush_no_valid", 32'(i_val_cnt - cnt0), 32'd0);
        chk("flush_rdata_kept", i_rdata, 32'hC0DE0003);
        fetch_stream(32'hBFC00380, 1);
        chk("refetch_data", i_rdata, 32'h40806000);

        // Load with a concurrent fetch waiting behind it.
        glog = '0; glen = 0;
        fork
            data_stream(32'h80000200, 4'h0, 32'h0, 1);
            fetch_stream(32'h00000030, 1);
        join
        chk("load_data", d_rdata, 32'h12345678);
        chk("load_latency", 32'(d_val_cyc - d_ce_cyc), 32'd3);
        chk("load_order", 32'(glog[1:0]), 32'h2);
        chk("load_fetch_data", i_rdata, 32'hC0DE000C);

        // Reset in the middle of a fetch read: no response, everything cleared.
        @(posedge cpu_clk_50M); #1;
        i_req = 1'b1; i_addr = 32'h00000010;
        wait_ce("reset_issue");
        @(posedge cpu_clk_50M); #1 cpu_rst = 1'b1; i_req = 1'b0;
        cnt0 = i_val_cnt;
        @(negedge cpu_clk_50M);
        chk("reset_s_ce", s_ce, 0);
        chk("reset_i_rdata_now", i_rdata, 0);
        @(posedge cpu_clk_50M); #1 cpu_rst = 1'b0;
        repeat (6) @(negedge cpu_clk_50M);
        $display("fetch addr=00000010 abandoned by reset");
        chk("reset_no_valid", 32'(i_val_cnt - cnt0), 32'd0);
        chk("reset_i_rdata", i_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
